// File: rtl/norm_pkg.sv
// ---------------------------------------------------------------------------
// norm_pkg
// Shared definitions for the normalize_pack block:
//   - state_t   : FSM state encoding (IDLE, NORM, DONE)
//   - EXP_W     : exponent field width
//   - MAN_W     : stored fraction width
//   - EXP_MAX   : all-ones exponent (infinity / overflow encoding)
//   - SIGN_BIT, EXP_MSB, EXP_LSB, FRAC_MSB, FRAC_LSB : packed-result field offsets
//   - pack_fp() : assembles {sign, exponent, fraction} into a 32-bit single
// ---------------------------------------------------------------------------
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    // Bit positions inside the packed IEEE-754 single result.
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_LSB = 0;

    function automatic logic [31:0] pack_fp(
        input logic        s,
        input logic [7:0]  e,
        input logic [22:0] f
    );
        logic [31:0] w;
        w                    = '0;
        w[SIGN_BIT]          = s;
        w[EXP_MSB:EXP_LSB]   = e;
        w[FRAC_MSB:FRAC_LSB] = f;
        return w;
    endfunction

endpackage

// File: rtl/lzc24.sv
// ---------------------------------------------------------------------------
// lzc24
// 24-bit leading-zero counter. Only built when NORM_FAST_LZC_EN is defined,
// since the iterative normaliser has no use for it.
// Ports:
//   din [23:0] : value to scan, bit 23 is the most significant
//   cnt [4:0]  : number of leading zeros, 24 when din is all zero
// ---------------------------------------------------------------------------
`ifdef NORM_FAST_LZC_EN
module lzc24 (
    input  logic [23:0] din,
    output logic [4:0]  cnt
);

    // Scan from LSB upward so the highest set bit is the last one to win.
    always_comb begin
        cnt = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (din[i]) begin
                cnt = 5'(23 - i);
            end
        end
    end

endmodule
`endif

// File: rtl/normalize_pack.sv
// ---------------------------------------------------------------------------
// normalize_pack
// Takes the raw sign/exponent/mantissa of a floating-point sum, normalises
// the mantissa (carry right shift or leading-zero left shift), detects
// overflow / underflow (flush-to-zero, truncating) and packs an IEEE-754
// single. One operand is in flight at a time: IDLE -> NORM -> DONE.
//
// Build option:
//   NORM_FAST_LZC_EN : when defined, NORM resolves in one cycle using a
//                      leading-zero counter and barrel shift; otherwise the
//                      mantissa is shifted left one bit per cycle. Results
//                      and flags are identical either way.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : operand valid
//   in_ready   : block idle and able to accept an operand
//   sign_in    : sign of the raw sum
//   exp_in     : common aligned exponent
//   mant_in    : raw mantissa, [24]=carry, [23]=hidden, [22:0]=fraction
//   out_valid  : result valid (held until out_ready)
//   out_ready  : consumer takes the result
//   result     : packed IEEE-754 single
//   ovf/unf/zero : status flags, meaningful while out_valid=1
// ---------------------------------------------------------------------------
module normalize_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign_in,
    input  logic [EXP_W-1:0]   exp_in,
    input  logic [MAN_W+1:0]   mant_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        result,
    output logic               ovf,
    output logic               unf,
    output logic               zero
);

    import norm_pkg::*;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [MAN_W+1:0]   mant_q, mant_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               zero_q, zero_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

`ifdef NORM_FAST_LZC_EN
    logic [4:0]         lz;
    logic [MAN_W-1:0]   frac_shl;

    lzc24 u_lzc24 (
        .din (mant_q[MAN_W:0]),
        .cnt (lz)
    );

    // Shifting only the stored fraction drops the leading one off the top,
    // which is exactly the hidden bit that must not be packed.
    assign frac_shl = mant_q[MAN_W-1:0] << lz;
`endif

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d  = sign_in;
                    exp_d   = exp_in;
                    mant_d  = mant_in;
                    state_d = NORM;
                end
            end

            NORM: begin
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                zero_d  = 1'b0;
                state_d = DONE;
                // Shifting only ever decrements the exponent and stops at 1,
                // so the all-ones and zero exponent tests below can only
                // trigger on the value captured from exp_in.
                if (exp_q == EXP_MAX) begin
                    result_d = pack_fp(sign_q, EXP_MAX, '0);
                    ovf_d    = 1'b1;
                end else if (exp_q == '0 && mant_q != '0) begin
                    result_d = pack_fp(sign_q, '0, '0);
                    unf_d    = 1'b1;
                    zero_d   = 1'b1;
                end else if (mant_q == '0) begin
                    result_d = pack_fp(sign_q, '0, '0);
                    zero_d   = 1'b1;
                end else if (mant_q[MAN_W+1]) begin
                    // Carry out: renormalise right by one, truncating bit 0.
                    if (exp_q >= EXP_MAX - 8'd1) begin
                        result_d = pack_fp(sign_q, EXP_MAX, '0);
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = pack_fp(sign_q, exp_q + 8'd1, mant_q[MAN_W:1]);
                    end
                end else if (mant_q[MAN_W]) begin
                    result_d = pack_fp(sign_q, exp_q, mant_q[MAN_W-1:0]);
`ifdef NORM_FAST_LZC_EN
                end else if (EXP_W'(lz) >= exp_q) begin
                    // The iterative path would hit exp==1 before the hidden
                    // bit reaches position 23.
                    result_d = pack_fp(sign_q, '0, '0);
                    unf_d    = 1'b1;
                    zero_d   = 1'b1;
                end else begin
                    result_d = pack_fp(sign_q, exp_q - EXP_W'(lz), frac_shl);
                end
`else
                end else if (exp_q == EXP_W'(1)) begin
                    result_d = pack_fp(sign_q, '0, '0);
                    unf_d    = 1'b1;
                    zero_d   = 1'b1;
                end else begin
                    mant_d  = {mant_q[MAN_W:0], 1'b0};
                    exp_d   = exp_q - EXP_W'(1);
                    state_d = NORM;
                end
`endif
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state, so
        // in_ready is low throughout DONE (including the release cycle).
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_normalize_pack.sv
// ---------------------------------------------------------------------------
// tb_normalize_pack
// Directed cases followed by random operands for normalize_pack, with
// expected results from an arithmetic reference model. Honours
// NORM_FAST_LZC_EN for the expected latency only.
// ---------------------------------------------------------------------------
module tb_normalize_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [24:0] mant_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        zero;

    int n_cmp;
    int n_err;

    normalize_pack #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain integer arithmetic on the value's magnitude.
    task automatic model(input logic s, input int e, input int m,
                         output logic [31:0] r, output logic o, output logic u,
                         output logic z, output int lat);
        int k;
        int mm;
        o = 1'b0; u = 1'b0; z = 1'b0; lat = 1;
        r = {s, 31'h0};
        if (e == 255) begin
            r = {s, 8'hFF, 23'h0}; o = 1'b1;
        end else if (e == 0 && m != 0) begin
            u = 1'b1; z = 1'b1;
        end else if (m == 0) begin
            z = 1'b1;
        end else if (m >= 32'h100_0000) begin
            if (e + 1 >= 255) begin
                r = {s, 8'hFF, 23'h0}; o = 1'b1;
            end else begin
                r = {s, 8'(e + 1), 23'((m / 2) % 32'h80_0000)};
            end
        end else begin
            k = 0; mm = m;
            while (mm < 32'h80_0000) begin
                mm = mm * 2; k++;
            end
            if (e - k < 1) begin
                u = 1'b1; z = 1'b1;
                lat = e;          // e-1 shifts, then the underflow decision
            end else begin
                r = {s, 8'(e - k), 23'(mm % 32'h80_0000)};
                lat = 1 + k;
            end
        end
`ifdef NORM_FAST_LZC_EN
        lat = 1;
`endif
    endtask

    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [24:0] m, input int hold,
                          input logic [31:0] xr, input logic xo, input logic xu,
                          input logic xz, input int xlat);
        int waitc;
        int lat;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; sign_in = s; exp_in = e; mant_in = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sign_in = 1'($urandom); exp_in = 8'($urandom); mant_in = 25'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(xlat));
        check({tag, ".result"}, 64'(result), 64'(xr));
        check({tag, ".flags"}, 64'({ovf, unf, zero}), 64'({xo, xu, xz}));
        check({tag, ".busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold"}, 64'({out_valid, in_ready, result, ovf, unf, zero}),
                  64'({1'b1, 1'b0, xr, xo, xu, xz}));
        end
        // Offer a new operand in the release cycle; it must not be taken.
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check({tag, ".release"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        $display("op %s s=%0d e=%0d m=%07h -> result=%08h ovf=%0d unf=%0d zero=%0d lat=%0d",
                 tag, s, e, m, result, ovf, unf, zero, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        int          e;
        int          m;
        logic [31:0] xr;
        logic        xo, xu, xz;
        int          xlat;
        int          waitc;
        logic        saw_valid;

        n_cmp = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sign_in = 1'b0; exp_in = '0; mant_in = '0;
        repeat (2) @(negedge clk);
        check("reset.outputs", 64'({in_ready, out_valid, result, ovf, unf, zero}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

`ifdef NORM_FAST_LZC_EN
        xlat = 1;
`else
        xlat = 24;
`endif
        run_op("exp130", 1'b0, 8'd130, 25'h080_0000, 0, 32'h4100_0000, 1'b0, 1'b0, 1'b0, 1);
        run_op("carry",  1'b0, 8'd127, 25'h100_0000, 1, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1);
        run_op("lz23",   1'b0, 8'd150, 25'h000_0001, 0, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, xlat);
        run_op("ovf",    1'b0, 8'd254, 25'h100_0000, 0, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, 1);
`ifdef NORM_FAST_LZC_EN
        xlat = 1;
`else
        xlat = 5;
`endif
        run_op("unf",    1'b1, 8'd5,   25'h000_0100, 0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, xlat);
        run_op("hold3",  1'b1, 8'd100, 25'h0C0_0000, 3, 32'hB240_0000, 1'b0, 1'b0, 1'b0, 1);
        run_op("zero",   1'b1, 8'd77,  25'h000_0000, 0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1);
        run_op("exp255", 1'b0, 8'd255, 25'h0A0_0000, 0, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, 1);
        run_op("exp0",   1'b0, 8'd0,   25'h080_0001, 0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1);

        // Reset while the operand is in NORM: no result may appear.
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        in_valid = 1'b1; sign_in = 1'b0; exp_in = 8'd150; mant_in = 25'h000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_norm.outputs", 64'({in_ready, out_valid, result, ovf, unf, zero}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        check("rst_norm.no_valid", 64'(saw_valid), 64'd0);
        $display("op rst_norm out_valid_seen=%0d", saw_valid);

        for (int n = 0; n < 250; n++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0: e = $urandom_range(0, 255);
                1: e = $urandom_range(1, 12);
                2: e = $urandom_range(240, 255);
                default: e = $urandom_range(100, 160);
            endcase
            m = int'(($urandom & 32'h1FF_FFFF) >> $urandom_range(0, 25));
            model(s, e, m, xr, xo, xu, xz, xlat);
            run_op($sformatf("rnd%0d", n), s, 8'(e), 25'(m), $urandom_range(0, 3),
                   xr, xo, xu, xz, xlat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/normalize_pack.md
NORMALIZE_PACK -- requirements
Module: normalize_pack

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input operand valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port sign_in  input  1  sign of the raw sum.
REQ-008 SHALL have port exp_in  input  EXP_W  common aligned exponent.
REQ-009 SHALL have port mant_in  input  MAN_W+2  raw mantissa sum: bit 24 is carry, bit 23 is hidden, bits 22:0 are fraction.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port result  output  32  packed IEEE-754 single.
REQ-013 SHALL have ports ovf, unf, zero  output  1 each  flags, qualified by out_valid.

Function
REQ-014 SHALL use FSM states IDLE, NORM and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE SHALL, on in_valid&&in_ready, register sign, exponent and mantissa and go to NORM.
REQ-016 NORM with mant[24]=1 SHALL pack mant>>1 and exp+1, then go to DONE.
REQ-017 NORM with mant[24:23]=01 SHALL pack unchanged, then go to DONE.
REQ-018 NORM with mant=0 SHALL pack {sign,0,0}, set zero=1, then go to DONE.
REQ-019 NORM otherwise SHALL shift the mantissa left 1 bit, decrement exp and stay in NORM, one bit per cycle.
REQ-020 Latency from the accept edge to out_valid SHALL be 1 cycle, plus k cycles for k leading zeros of mant[23:0].
REQ-021 Overflow: if the carry case yields exp >= 255, or exp_in==255, SHALL produce {sign,8'hFF,23'h0} with ovf=1.
REQ-022 Underflow: if a left shift is needed with exp==1, or exp_in==0 with a nonzero mantissa, SHALL produce {sign,31'h0} with unf=1 and zero=1 (flush-to-zero, no denormals).
REQ-023 Rounding SHALL be truncation; bits shifted out on the right SHALL be discarded.
REQ-024 DONE SHALL hold out_valid=1 and keep result and flags stable until out_ready=1, then return to IDLE on that edge.
REQ-025 An operand SHALL NOT be accepted in the DONE cycle in which out_ready=1; acceptance resumes in the next IDLE cycle.

Reset
REQ-026 rst SHALL asynchronously force IDLE, out_valid=0, result=0, ovf=unf=zero=0 and in_ready=0 while asserted.
REQ-027 Reset during NORM or DONE SHALL abandon the operation with no output produced.

Configuration
REQ-028 With macro NORM_FAST_LZC_EN defined, NORM SHALL apply a leading-zero count and a barrel left shift in one cycle, giving latency exactly 1 for every input.
REQ-029 Without NORM_FAST_LZC_EN, NORM SHALL use the iterative one-bit-per-cycle shift of REQ-019.
REQ-030 Results and flags SHALL be bit-identical in both configurations.

Structure
REQ-031 Package norm_pkg SHALL hold the FSM state enum, EXP_MAX=8'hFF, EXP_W, MAN_W and the packed-result field offsets.
REQ-032 Sub-module lzc24 (24-bit leading-zero counter, 5-bit output) SHALL be instantiated only under NORM_FAST_LZC_EN.

Verification
REQ-033 sign=0, exp=130, mant=25'h0800000 -> result=32'h41000000, flags 0, out_valid 1 cycle after accept.
REQ-034 exp=127, mant=25'h1000000 -> result=32'h40000000 after 1 cycle.
REQ-035 exp=150, mant=25'h0000001 -> result=32'h3F800000 after 24 cycles (iterative) or 1 cycle (NORM_FAST_LZC_EN).
REQ-036 exp=254, mant=25'h1000000 -> result=32'h7F800000, ovf=1.
REQ-037 sign=1, exp=5, mant=25'h0000100 -> result=32'h80000000, unf=1, zero=1.
REQ-038 Hold out_ready=0 for 3 cycles in DONE -> result stable and in_ready=0; rst pulse mid-NORM -> IDLE with no out_valid.
